data_ram_dp: RTL and testbench

Parametrised dual-port synchronous data RAM for the single-cycle RISC-V core, successor to the fixed 256x32 single-port block RAM. Port A is read/write with per-byte write enables (store path); port B is read-only (debug/fetch path). A built-in clear engine zeroes the whole array after reset or on request, and `ready` gates all accesses while the clear runs. Read-during-write collision behaviour is selectable by parameter.

---
 rtl/data_ram_dp.sv | 96 +++++++++
 tb/tb_data_ram_dp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_dp.sv
// Dual-port synchronous data RAM: port A read/write with byte enables, port B read-only.
// A clear engine zeroes the array after reset or on request; ready is low while it runs.
module data_ram_dp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int WR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  ready,
    input  logic                  en_a,
    input  logic [DATA_W/8-1:0]   we_a,
    input  logic [ADDR_W-1:0]     addr_a,
    input  logic [DATA_W-1:0]     din_a,
    output logic [DATA_W-1:0]     dout_a,
    input  logic                  en_b,
    input  logic [ADDR_W-1:0]     addr_b,
    output logic [DATA_W-1:0]     dout_b
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W/8;

    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NB-1:0]     wr_a;
    logic [DATA_W-1:0] rd_a, rd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == '1) state_nxt = READY;
            end
            READY: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign ready = (state == READY);
    assign wr_a  = (state == READY && en_a) ? we_a : '0;

    // Write-first bypass substitutes the incoming bytes; read-first just sees the old array word.
    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
        for (int i = 0; i < NB; i++) begin
            if (WR_MODE == 1 && wr_a[i])
                rd_a[8*i +: 8] = din_a[8*i +: 8];
            if (WR_MODE == 1 && wr_a[i] && addr_a == addr_b)
                rd_b[8*i +: 8] = din_a[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < NB; i++)
                if (wr_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_a <= '0;
            dout_b <= '0;
        end else if (state == CLEAR) begin
            dout_a <= '0;
            dout_b <= '0;
        end else begin
            if (en_a) dout_a <= rd_a;
            if (en_b) dout_b <= rd_b;
        end
    end
endmodule

// File: tb/tb_data_ram_dp.sv
// Directed bench for data_ram_dp: read-first and write-first 256x32 instances plus a 16x64 instance.
module tb_data_ram_dp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_req;
    logic        en_a, en_b;
    logic [3:0]  we_a;
    logic [7:0]  addr_a, addr_b;
    logic [31:0] din_a;
    logic        ready0, ready1;
    logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;

    logic        clear_req2, en_a2, en_b2;
    logic [7:0]  we_a2;
    logic [3:0]  addr_a2, addr_b2;
    logic [63:0] din_a2;
    logic        ready2;
    logic [63:0] dout_a2, dout_b2;

    int passed = 0;
    int total  = 0;
    int n, c2, nz;

    always #5 clk = ~clk;

    data_ram_dp #(.DATA_W(32), .ADDR_W(8), .WR_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready0),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a0),
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b0));

    data_ram_dp #(.DATA_W(32), .ADDR_W(8), .WR_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .ready(ready1),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a1),
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout_b1));

    data_ram_dp #(.DATA_W(64), .ADDR_W(4), .WR_MODE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req2), .ready(ready2),
        .en_a(en_a2), .we_a(we_a2), .addr_a(addr_a2), .din_a(din_a2), .dout_a(dout_a2),
        .en_b(en_b2), .addr_b(addr_b2), .dout_b(dout_b2));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear_req = 1'b0;
        en_a = 1'b0; en_b = 1'b0; we_a = '0; addr_a = '0; addr_b = '0; din_a = '0;
        clear_req2 = 1'b0; en_a2 = 1'b0; en_b2 = 1'b0; we_a2 = '0;
        addr_a2 = '0; addr_b2 = '0; din_a2 = '0;
        repeat (3) step();
        check("reset_ready", ready0, 0);
        check("reset_dout_a", dout_a0, 0);
        check("reset_dout_b", dout_b1, 0);

        // Post-reset clear length
        rst_n = 1'b1;
        n = 0; c2 = 0;
        while (!ready0 && n < 1000) begin
            step(); n++;
            if (ready2 && c2 == 0) c2 = n;
        end
        check("clear_cycles_256", n, 256);
        check("clear_ready_wm1", ready1, 1);
        check("clear_cycles_16", c2, 16);

        en_a = 1'b1; en_b = 1'b1; addr_a = 8'h00; addr_b = 8'hFF;
        step();
        check("rd0_a", dout_a0, 0);
        check("rdff_b", dout_b0, 0);
        addr_a = 8'hFF; addr_b = 8'h00;
        step();
        check("rdff_a", dout_a0, 0);
        check("rd0_b", dout_b0, 0);

        // Full-word write then read on both ports
        en_b = 1'b0; we_a = 4'hF; addr_a = 8'h05; din_a = 32'hDEADBEEF;
        step();
        we_a = 4'h0; en_b = 1'b1; addr_b = 8'h05;
        step();
        check("word_a_wm0", dout_a0, 32'hDEADBEEF);
        check("word_b_wm0", dout_b0, 32'hDEADBEEF);
        check("word_a_wm1", dout_a1, 32'hDEADBEEF);
        check("word_b_wm1", dout_b1, 32'hDEADBEEF);

        // Byte write: read-first returns old word, write-first merges new byte
        en_b = 1'b0; we_a = 4'b0010; din_a = 32'h0000AB00;
        step();
        check("bytew_old_wm0", dout_a0, 32'hDEADBEEF);
        check("bytew_new_wm1", dout_a1, 32'hDEADABEF);
        we_a = 4'h0;
        step();
        check("byte_rd_wm0", dout_a0, 32'hDEADABEF);
        check("byte_rd_wm1", dout_a1, 32'hDEADABEF);
        en_a = 1'b0; addr_a = 8'h00;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_a", dout_a0, 32'hDEADABEF);
        end

        // Collision on address 7
        en_a = 1'b1; we_a = 4'hF; addr_a = 8'h07; din_a = 32'h11111111;
        step();
        din_a = 32'h22222222; en_b = 1'b1; addr_b = 8'h07;
        step();
        check("coll_b_wm0", dout_b0, 32'h11111111);
        check("coll_b_wm1", dout_b1, 32'h22222222);
        we_a = 4'h0;
        step();
        check("after_coll_wm0", dout_b0, 32'h22222222);
        check("after_coll_wm1", dout_b1, 32'h22222222);

        // Runtime clear; a write into an already-cleared address must be lost
        en_a = 1'b0; en_b = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0; n = 1;
        check("clr_ready_drop", ready0, 0);
        while (!ready0 && n < 600) begin
            if (n == 12) begin
                en_a = 1'b1; we_a = 4'hF; addr_a = 8'h02; din_a = 32'hAAAAAAAA;
                en_b = 1'b1; addr_b = 8'h07;
            end else begin
                en_a = 1'b0; we_a = 4'h0; en_b = 1'b0;
            end
            step(); n++;
            if (n == 13) begin
                check("clr_dout_a", dout_a0, 0);
                check("clr_dout_b", dout_b0, 0);
            end
        end
        check("clr_edges", n, 257);
        nz = 0;
        en_a = 1'b1; en_b = 1'b1; we_a = 4'h0;
        for (int a = 0; a < 256; a++) begin
            addr_a = 8'(a); addr_b = 8'(255 - a);
            step();
            if (dout_a0 !== 0 || dout_b0 !== 0 || dout_a1 !== 0) nz++;
        end
        check("clr_all_zero", nz, 0);
        addr_a = 8'h02;
        step();
        check("clr_lost_write", dout_a0, 0);

        // Reset mid-clear at counter 100
        en_a = 1'b0; en_b = 1'b0; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (100) step();
        #2 rst_n = 1'b0;
        #1;
        check("midclr_ready", ready0, 0);
        check("midclr_dout", dout_a0, 0);
        step();
        rst_n = 1'b1;
        n = 0;
        while (!ready0 && n < 1000) begin
            step(); n++;
        end
        check("midclr_cycles", n, 256);

        // Async reset from READY with nonzero dout
        en_a = 1'b1; we_a = 4'hF; addr_a = 8'h09; din_a = 32'hCAFEF00D;
        step();
        we_a = 4'h0;
        step();
        check("pre_rst_dout", dout_a0, 32'hCAFEF00D);
        en_a = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("async_ready", ready0, 0);
        check("async_dout_a0", dout_a0, 0);
        check("async_dout_a1", dout_a1, 0);
        step(); step();
        rst_n = 1'b1;
        n = 0; c2 = 0;
        while (!ready0 && n < 1000) begin
            step(); n++;
            if (ready2 && c2 == 0) c2 = n;
        end
        check("rerun_cycles_256", n, 256);
        check("rerun_cycles_16", c2, 16);

        // 64-bit instance byte write
        en_a2 = 1'b1; we_a2 = 8'hFF; addr_a2 = 4'h3; din_a2 = 64'h0123456789ABCDEF;
        step();
        we_a2 = 8'b0010_0000; din_a2 = 64'h0000AA0000000000;
        step();
        check("w64_old", dout_a2, 64'h0123456789ABCDEF);
        we_a2 = 8'h00; en_b2 = 1'b1; addr_b2 = 4'h3;
        step();
        check("w64_byte_a", dout_a2, 64'h0123AA6789ABCDEF);
        check("w64_byte_b", dout_b2, 64'h0123AA6789ABCDEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
